// File: rtl/sisc_ifetch.sv
// SISC instruction fetch unit: owns the PC, fetches over a req/ack memory
// handshake and presents each word on ir until the core accepts it.
module sisc_ifetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_req,
    input  logic              im_ack,
    input  logic [31:0]       im_data,
    output logic [31:0]       ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [ADDR_W-1:0] pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              halt
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] next_addr, next_addr_d;
    logic [ADDR_W-1:0] im_addr_d, pc_d;
    logic [31:0]       ir_d;
    logic              im_req_d, ir_valid_d;
    logic              accept;

    // Core acceptance only counts while an instruction is actually presented.
    assign accept = ir_valid && ir_ready;

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q   <= S_FETCH;
            im_req    <= 1'b0;
            im_addr   <= RESET_PC;
            next_addr <= RESET_PC;
            ir        <= '0;
            ir_valid  <= 1'b0;
            pc        <= RESET_PC;
        end else begin
            state_q   <= state_d;
            im_req    <= im_req_d;
            im_addr   <= im_addr_d;
            next_addr <= next_addr_d;
            ir        <= ir_d;
            ir_valid  <= ir_valid_d;
            pc        <= pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        im_req_d    = im_req;
        im_addr_d   = im_addr;
        next_addr_d = next_addr;
        ir_d        = ir;
        ir_valid_d  = ir_valid;
        pc_d        = pc;

        case (state_q)
            S_FETCH: begin
                // im_req is low only in the cycle right after reset.
                if (!im_req) begin
                    im_req_d = 1'b1;
                end else if (im_ack) begin
                    ir_d        = im_data;
                    pc_d        = im_addr;
                    next_addr_d = im_addr + ADDR_W'(1);
                    ir_valid_d  = 1'b1;
                    im_req_d    = 1'b0;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    ir_valid_d = 1'b0;
                    if (halt) begin
                        state_d = S_HALTED;
                    end else begin
                        if (br_taken) begin
                            im_addr_d   = br_addr;
                            next_addr_d = br_addr;
                        end else begin
                            im_addr_d = next_addr;
                        end
                        im_req_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_HALTED: begin
                im_req_d   = 1'b0;
                ir_valid_d = 1'b0;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_sisc_ifetch.sv
// Self-checking bench for sisc_ifetch: directed scenarios plus a randomized
// run scored against a simple program-counter stream model.
module tb_sisc_ifetch;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic [15:0] im_addr, pc, br_addr;
    logic        im_req, im_ack, ir_valid, ir_ready, br_taken, halt;
    logic [31:0] im_data, ir;

    // second instance, reset PC at the top of the address space
    logic [15:0] im_addr_w, pc_w;
    logic        im_req_w, ir_valid_w;
    logic [31:0] ir_w;

    int errors = 0;
    int checks = 0;
    int lat = 0;
    bit rand_lat = 0;
    int wcnt = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [15:0] a);
        case (a)
            16'd0:   return 32'h11110001;
            16'd1:   return 32'h22220002;
            16'd2:   return 32'h33330003;
            default: return {~a, a};
        endcase
    endfunction

    sisc_ifetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_f(rst_f), .im_addr(im_addr), .im_req(im_req),
        .im_ack(im_ack), .im_data(im_data), .ir(ir), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .pc(pc), .br_taken(br_taken), .br_addr(br_addr),
        .halt(halt)
    );

    sisc_ifetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_w (
        .clk(clk), .rst_f(rst_f), .im_addr(im_addr_w), .im_req(im_req_w),
        .im_ack(im_req_w), .im_data(mem(im_addr_w)), .ir(ir_w),
        .ir_valid(ir_valid_w), .ir_ready(1'b1), .pc(pc_w), .br_taken(1'b0),
        .br_addr(16'h0000), .halt(1'b0)
    );

    // Memory model: acks after `lat` wait cycles, updates just after each edge.
    initial begin
        im_ack  = 1'b0;
        im_data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!im_req) begin
                im_ack = 1'b0;
                wcnt   = 0;
            end else if (!im_ack) begin
                if (wcnt >= lat) begin
                    im_ack  = 1'b1;
                    im_data = mem(im_addr);
                    if (rand_lat) lat = $urandom_range(0, 3);
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_f = 1'b1;
        @(negedge clk);
        rst_f = 1'b0;
    endtask

    task automatic test_reset();
        ir_ready = 1'b1; br_taken = 1'b1; halt = 1'b0; br_addr = 16'h1234;
        lat = 0;
        do_reset();
        checks++;
        if (im_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 32'h0 ||
            pc !== 16'h0 || im_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b ir=%h pc=%h addr=%h, want 0/0/0/0/0",
                     im_req, ir_valid, ir, pc, im_addr);
        end
        checks++;
        if (pc_w !== 16'hFFFF || im_addr_w !== 16'hFFFF || im_req_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_pc_param: pc=%h addr=%h req=%b, want ffff/ffff/0",
                     pc_w, im_addr_w, im_req_w);
        end
        br_taken = 1'b0;
    endtask

    task automatic test_sequential();
        ir_ready = 1'b1; lat = 0; rand_lat = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (ir_valid !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL seq_valid[%0d]: got %b want %b", k, ir_valid, (k % 2 == 1));
            end
            if (k % 2 == 0) begin
                checks++;
                if (im_req !== 1'b1 || im_addr !== 16'(k / 2)) begin
                    errors++;
                    $display("FAIL seq_addr[%0d]: req=%b addr=%h want 1/%h", k, im_req, im_addr, k / 2);
                end
            end else begin
                checks++;
                if (pc !== 16'(k / 2) || ir !== mem(16'(k / 2))) begin
                    errors++;
                    $display("FAIL seq_ir[%0d]: pc=%h ir=%h want %h/%h", k, pc, ir, k / 2, mem(16'(k / 2)));
                end
            end
        end
    endtask

    task automatic test_wait_backpressure();
        bit got = 0;
        ir_ready = 1'b0; lat = 3; rand_lat = 0;
        do_reset();
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (ir_valid) got = 1;
            else begin
                checks++;
                if (im_req !== 1'b1 || im_addr !== 16'h0) begin
                    errors++;
                    $display("FAIL wait_stable: req=%b addr=%h want 1/0000", im_req, im_addr);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_timeout: ir_valid=%b want 1 within 20 cycles", ir_valid);
        end
        for (int h = 0; h < 4; h++) begin
            if (h > 0) @(negedge clk);
            checks++;
            if (ir_valid !== 1'b1 || ir !== mem(16'h0) || pc !== 16'h0 || im_req !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%b ir=%h pc=%h req=%b want 1/%h/0000/0",
                         h, ir_valid, ir, pc, im_req, mem(16'h0));
            end
        end
        ir_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ir_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 16'h1) begin
            errors++;
            $display("FAIL after_accept: valid=%b req=%b addr=%h want 0/1/0001", ir_valid, im_req, im_addr);
        end
    endtask

    task automatic test_branch();
        bit seen[int];
        logic [15:0] acc[$];
        logic [15:0] want[$] = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h40, 16'h41};
        bit pulsed = 0, done = 0, redir = 0;
        lat = 0; rand_lat = 1; ir_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (redir) begin
                redir = 0;
                checks++;
                if (im_req !== 1'b1 || im_addr !== 16'h0040) begin
                    errors++;
                    $display("FAIL redirect_addr: req=%b addr=%h want 1/0040", im_req, im_addr);
                end
            end
            if (im_req) seen[int'(im_addr)] = 1;
            br_taken = 1'b0; ir_ready = 1'b1; halt = 1'b0;
            if (ir_valid) begin
                if (pc == 16'h5 && !pulsed) begin
                    ir_ready = 1'b0; br_taken = 1'b1; br_addr = 16'h0080; pulsed = 1;
                end else begin
                    acc.push_back(pc);
                    checks++;
                    if (ir !== mem(pc)) begin
                        errors++;
                        $display("FAIL br_ir: pc=%h ir=%h want %h", pc, ir, mem(pc));
                    end
                    if (pc == 16'h5) begin
                        br_taken = 1'b1; br_addr = 16'h0040; redir = 1;
                    end
                    if (pc == 16'h41) done = 1;
                end
            end
        end
        br_taken = 1'b0;
        checks++;
        if (acc.size() != want.size() || acc != want) begin
            errors++;
            $display("FAIL br_stream: got %p want %p", acc, want);
        end
        checks++;
        if (seen.exists(6) || seen.exists(16'h80)) begin
            errors++;
            $display("FAIL br_old_path: addr6=%0d addr80=%0d requested, want neither",
                     seen.exists(6), seen.exists(16'h80));
        end
    endtask

    task automatic test_halt();
        bit done = 0;
        lat = 1; rand_lat = 0; ir_ready = 1'b1; halt = 1'b0; br_taken = 1'b0;
        do_reset();
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (ir_valid && pc == 16'h3) begin
                halt = 1'b1; br_taken = 1'b1; br_addr = 16'h0077; done = 1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL halt_reach: pc=%h want 0003 presented", pc);
        end
        @(negedge clk);
        halt = 1'b0; br_taken = 1'b0;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (im_req !== 1'b0 || ir_valid !== 1'b0 || pc !== 16'h3 || ir !== mem(16'h3)) begin
                errors++;
                $display("FAIL halted[%0d]: req=%b valid=%b pc=%h ir=%h want 0/0/0003/%h",
                         c, im_req, ir_valid, pc, ir, mem(16'h3));
            end
            br_taken = c[0]; halt = c[1];
            @(negedge clk);
        end
        halt = 1'b0; br_taken = 1'b0;
        do_reset();
        @(negedge clk);
        checks++;
        if (im_req !== 1'b1 || im_addr !== 16'h0) begin
            errors++;
            $display("FAIL halt_resume: req=%b addr=%h want 1/0000", im_req, im_addr);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] acc[$];
        do_reset();
        for (int c = 0; c < 20 && acc.size() < 2; c++) begin
            @(negedge clk);
            if (ir_valid_w) begin
                acc.push_back(pc_w);
                checks++;
                if (ir_w !== mem(pc_w)) begin
                    errors++;
                    $display("FAIL wrap_ir: pc=%h ir=%h want %h", pc_w, ir_w, mem(pc_w));
                end
            end
        end
        checks++;
        if (acc.size() != 2 || acc[0] !== 16'hFFFF || acc[1] !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_pcs: got %p want '{ffff, 0000}", acc);
        end
    endtask

    task automatic test_reset_midfetch();
        bit got = 0;
        lat = 0; rand_lat = 0; ir_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (ir_valid) got = 1;
        end
        lat = 5; ir_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (im_req !== 1'b1 || im_addr !== 16'h1 || ir !== mem(16'h0)) begin
            errors++;
            $display("FAIL mid_pending: req=%b addr=%h ir=%h want 1/0001/%h", im_req, im_addr, ir, mem(16'h0));
        end
        rst_f = 1'b1;
        @(negedge clk);
        rst_f = 1'b0;
        checks++;
        if (im_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 32'h0 || pc !== 16'h0 || im_addr !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset: req=%b valid=%b ir=%h pc=%h addr=%h want 0/0/0/0/0",
                     im_req, ir_valid, ir, pc, im_addr);
        end
        lat = 0;
        @(negedge clk);
        checks++;
        if (im_req !== 1'b1 || im_addr !== 16'h0) begin
            errors++;
            $display("FAIL mid_refetch: req=%b addr=%h want 1/0000", im_req, im_addr);
        end
        @(negedge clk);
        checks++;
        if (ir_valid !== 1'b1 || pc !== 16'h0 || ir !== mem(16'h0)) begin
            errors++;
            $display("FAIL mid_first: valid=%b pc=%h ir=%h want 1/0000/%h", ir_valid, pc, ir, mem(16'h0));
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc = 16'h0;
        rand_lat = 1; lat = 2; halt = 1'b0; ir_ready = 1'b0; br_taken = 1'b0;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            checks++;
            if (ir_valid) begin
                if (pc !== exp_pc || ir !== mem(exp_pc)) begin
                    errors++;
                    $display("FAIL rnd_ir[%0d]: pc=%h ir=%h want %h/%h", c, pc, ir, exp_pc, mem(exp_pc));
                end
            end else if (im_req !== 1'b1 || im_addr !== exp_pc) begin
                errors++;
                $display("FAIL rnd_fetch[%0d]: req=%b addr=%h want 1/%h", c, im_req, im_addr, exp_pc);
            end
            ir_ready = 1'($urandom_range(0, 1));
            br_taken = ($urandom_range(0, 3) == 0);
            br_addr  = 16'($urandom);
            if (ir_valid && ir_ready) exp_pc = br_taken ? br_addr : exp_pc + 16'h1;
        end
        rand_lat = 0; br_taken = 1'b0;
    endtask

    initial begin
        ir_ready = 1'b0; br_taken = 1'b0; br_addr = '0; halt = 1'b0;
        test_reset();
        test_sequential();
        test_wait_backpressure();
        test_branch();
        test_halt();
        test_wrap();
        test_reset_midfetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
